// File: rtl/fwd_scoreboard.sv
// Scoreboard-based operand forwarding and decode stall unit.
// Define FWD_MDU_BUSY_EN to stall decode while the mul/div unit is busy.
module fwd_scoreboard #(
  parameter int NREAD = 4,
  parameter int DEPTH = 3,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int TW    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               iss_valid,
  input  logic [AW-1:0]      iss_waddr,
  input  logic [TW-1:0]      iss_tnew,
  input  logic [DEPTH*DW-1:0] stage_data,
  input  logic [NREAD*AW-1:0] rd_addr,
  input  logic [NREAD*TW-1:0] rd_tuse,
  input  logic [NREAD*DW-1:0] rd_regfile,
  output logic [NREAD*DW-1:0] fwd_data,
  output logic [NREAD-1:0]   fwd_hit,
  output logic [NREAD-1:0]   fwd_pend,
  output logic               stall_d,
  input  logic               mdu_start,
  input  logic [3:0]         mdu_cycles,
  input  logic               mdu_use
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [AW-1:0]    addr_d [DEPTH];
  logic [TW-1:0]    tnew_q [DEPTH];
  logic [TW-1:0]    tnew_d [DEPTH];
  logic [NREAD-1:0] stall_req;
  logic             mdu_stall;

  // A stalled decode slot enters E as a bubble.
  always_comb begin
    vld_d     = '0;
    vld_d[0]  = iss_valid & ~stall_d & (iss_waddr != '0);
    addr_d[0] = iss_waddr;
    tnew_d[0] = iss_tnew;
    for (int k = 1; k < DEPTH; k++) begin
      vld_d[k]  = vld_q[k-1];
      addr_d[k] = addr_q[k-1];
      tnew_d[k] = (tnew_q[k-1] != '0) ? tnew_q[k-1] - TW'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= '0;
        tnew_q[k] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
      tnew_q <= tnew_d;
    end
  end

  // Lowest k is the youngest producer and shadows older ones.
  always_comb begin
    logic          found;
    logic [AW-1:0] ra;
    logic [TW-1:0] tu;
    fwd_data  = rd_regfile;
    fwd_hit   = '0;
    fwd_pend  = '0;
    stall_req = '0;
    for (int p = 0; p < NREAD; p++) begin
      found = 1'b0;
      ra    = rd_addr[p*AW +: AW];
      tu    = rd_tuse[p*TW +: TW];
      for (int k = 0; k < DEPTH; k++) begin
        if (!found && vld_q[k] && ra != '0 && addr_q[k] == ra) begin
          found = 1'b1;
          if (tnew_q[k] == '0) begin
            fwd_hit[p]            = 1'b1;
            fwd_data[p*DW +: DW]  = stage_data[k*DW +: DW];
          end else if (tnew_q[k] <= tu) begin
            fwd_pend[p] = 1'b1;
          end else begin
            stall_req[p] = 1'b1;
          end
        end
      end
    end
  end

`ifdef FWD_MDU_BUSY_EN
  logic [3:0] mdu_cnt_q, mdu_cnt_d;

  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (mdu_start & iss_valid & ~stall_d)
      mdu_cnt_d = mdu_cycles;
    else if (mdu_cnt_q != 4'd0)
      mdu_cnt_d = mdu_cnt_q - 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mdu_cnt_q <= 4'd0;
    else        mdu_cnt_q <= mdu_cnt_d;
  end

  assign mdu_stall = mdu_use & (mdu_cnt_q != 4'd0);
`else
  logic unused_mdu;
  assign unused_mdu = ^{mdu_start, mdu_cycles, mdu_use};
  assign mdu_stall  = 1'b0;
`endif

  assign stall_d = (|stall_req) | mdu_stall;

endmodule
